ip_codma_ap_engine: RTL and testbench

//  Parametrised address-phase engine for the codma bus master.
//  - Buffers read/write address requests from the DMA control FSM in a REQ_DEPTH FIFO.
//  - Issues them on the bus address phase with a req/grant handshake.
//  - Tracks up to MAX_OUTSTANDING granted phases awaiting data-phase completion.
//  - Pushes one tracker entry per grant to the data-phase machine.
//  - Supports pipelined multi-outstanding issue, read/write direction fencing, and stop/error flush.

---
 rtl/ip_codma_ap_engine.sv | 151 +++++++++++++++
 tb/tb_ip_codma_ap_engine.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_codma_ap_engine.sv
// Address-phase engine for the codma bus master: buffers address requests, issues them
// with a req/grant handshake, tracks outstanding phases, fences direction changes, flushes on stop/error.
module ip_codma_ap_engine #(
  parameter int ADDR_W          = 32,
  parameter int SIZE_W          = 4,
  parameter int REQ_DEPTH       = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic                                 stop_i,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic [ADDR_W-1:0]                    req_addr_i,
  input  logic                                 req_write_i,
  input  logic [SIZE_W-1:0]                    req_size_i,
  output logic                                 bus_req_o,
  output logic [ADDR_W-1:0]                    bus_addr_o,
  output logic                                 bus_write_o,
  output logic [SIZE_W-1:0]                    bus_size_o,
  input  logic                                 bus_grant_i,
  input  logic                                 bus_error_i,
  input  logic                                 dp_done_i,
  output logic                                 tk_push_o,
  output logic                                 tk_write_o,
  output logic [SIZE_W-1:0]                    tk_size_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 idle_o,
  output logic                                 ap_state_error_o
);

  localparam int PTR_W = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int CNT_W = $clog2(REQ_DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_FENCE = 3'd2,
    ST_FLUSH = 3'd3
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_mem  [REQ_DEPTH];
  logic              write_mem [REQ_DEPTH];
  logic [SIZE_W-1:0] size_mem  [REQ_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [OUT_W-1:0] outstanding_q;
  logic             inflight_write_q;
  logic             error_q;

  logic fifo_empty, fifo_full, flush_req, blocked, grant, push, dp_dec, dp_spurious, illegal_state;
  logic head_write;

  assign head_write  = write_mem[rd_ptr_q];
  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == CNT_W'(REQ_DEPTH));
  assign flush_req   = stop_i | bus_error_i;

  // Reads and writes never overlap on the bus, and the tracker depth is bounded.
  assign blocked     = (outstanding_q == OUT_W'(MAX_OUTSTANDING)) ||
                       ((outstanding_q != '0) && (head_write != inflight_write_q));

  assign bus_req_o   = (state_q == ST_ISSUE) && !fifo_empty && !blocked;
  assign grant       = bus_req_o && bus_grant_i;
  // A grant frees the head slot in the same cycle, so a full FIFO can still take a push.
  assign req_ready_o = (state_q != ST_FLUSH) && (!fifo_full || grant);
  assign push        = req_valid_i && req_ready_o;
  assign dp_dec      = dp_done_i && (outstanding_q != '0);
  assign dp_spurious = dp_done_i && (outstanding_q == '0);

  assign bus_addr_o  = bus_req_o ? addr_mem[rd_ptr_q] : '0;
  assign bus_write_o = bus_req_o && head_write;
  assign bus_size_o  = bus_req_o ? size_mem[rd_ptr_q] : '0;
  assign tk_push_o   = grant;
  assign tk_write_o  = grant && head_write;
  assign tk_size_o   = grant ? size_mem[rd_ptr_q] : '0;

  assign outstanding_o    = outstanding_q;
  assign idle_o           = fifo_empty && (outstanding_q == '0) && (state_q == ST_IDLE);
  assign ap_state_error_o = error_q;

  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[wr_ptr_q]  <= req_addr_i;
      write_mem[wr_ptr_q] <= req_write_i;
      size_mem[wr_ptr_q]  <= req_size_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_req) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (grant) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(grant);
    end
  end

  // A grant in a flush cycle was already issued on the bus, so it is still tracked.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      outstanding_q    <= '0;
      inflight_write_q <= 1'b0;
      error_q          <= 1'b0;
    end else begin
      if (grant && !dp_dec)      outstanding_q <= outstanding_q + OUT_W'(1);
      else if (!grant && dp_dec) outstanding_q <= outstanding_q - OUT_W'(1);
      if (grant) inflight_write_q <= head_write;
      error_q <= error_q | bus_error_i | dp_spurious | illegal_state;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    illegal_state = 1'b0;
    case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (fifo_empty)   state_d = ST_IDLE;
        else if (blocked) state_d = ST_FENCE;
      end
      ST_FENCE: begin
        if (fifo_empty)    state_d = ST_IDLE;
        else if (!blocked) state_d = ST_ISSUE;
      end
      ST_FLUSH: if (outstanding_q == '0) state_d = ST_IDLE;
      default: begin
        state_d       = ST_IDLE;
        illegal_state = 1'b1;
      end
    endcase
    if (flush_req) state_d = ST_FLUSH;
  end

endmodule

// File: tb/tb_ip_codma_ap_engine.sv
// Self-checking bench for ip_codma_ap_engine: request table, grant scoreboard and
// hand-written sequences for fencing, flush, FIFO wrap and reset.
module tb_ip_codma_ap_engine;

  localparam int ADDR_W = 32;
  localparam int SIZE_W = 4;
  localparam int OUT_W  = 3;

  logic              clk_i = 1'b0;
  logic              reset_n_i, stop_i, req_valid_i, req_ready_o, req_write_i;
  logic [ADDR_W-1:0] req_addr_i, bus_addr_o;
  logic [SIZE_W-1:0] req_size_i, bus_size_o, tk_size_o;
  logic              bus_req_o, bus_write_o, bus_grant_i, bus_error_i, dp_done_i;
  logic              tk_push_o, tk_write_o, idle_o, ap_state_error_o;
  logic [OUT_W-1:0]  outstanding_o;

  ip_codma_ap_engine #(
    .ADDR_W(ADDR_W), .SIZE_W(SIZE_W), .REQ_DEPTH(4), .MAX_OUTSTANDING(4)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .stop_i(stop_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_write_i(req_write_i), .req_size_i(req_size_i),
    .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o), .bus_write_o(bus_write_o),
    .bus_size_o(bus_size_o), .bus_grant_i(bus_grant_i), .bus_error_i(bus_error_i),
    .dp_done_i(dp_done_i), .tk_push_o(tk_push_o), .tk_write_o(tk_write_o),
    .tk_size_o(tk_size_o), .outstanding_o(outstanding_o), .idle_o(idle_o),
    .ap_state_error_o(ap_state_error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [SIZE_W-1:0] size;
  } req_vec_t;

  req_vec_t vec_tbl [24];
  req_vec_t sb_q [$];
  int       grant_cyc_q [$];
  int       check_count = 0;
  int       pass_count  = 0;
  int       grant_count = 0;
  int       cyc         = 0;
  int       base;
  logic     last_tk_write = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Every granted phase must match the oldest accepted request still queued.
  always @(negedge clk_i) begin
    if (reset_n_i && bus_req_o && bus_grant_i) begin
      req_vec_t exp_v;
      grant_count++;
      grant_cyc_q.push_back(cyc);
      last_tk_write = tk_write_o;
      if (sb_q.size() == 0) begin
        check_count++;
        $display("[TB] FAIL sb_grant: grant of 0x%0h with no request expected", bus_addr_o);
      end else begin
        exp_v = sb_q.pop_front();
        checkOutput("bus_addr", bus_addr_o, exp_v.addr);
        checkOutput("bus_write", bus_write_o, exp_v.write);
        checkOutput("tk_push", tk_push_o, 1);
        checkOutput("tk_write", tk_write_o, exp_v.write);
        checkOutput("tk_size", tk_size_o, exp_v.size);
      end
    end
  end

  task automatic alignDrive();
    @(posedge clk_i);
    #1;
  endtask

  // Called at posedge+1; holds the request until accepted and queues the expected phase.
  task automatic applyStimulus(input req_vec_t v);
    logic accepted;
    accepted    = 1'b0;
    req_valid_i = 1'b1;
    req_addr_i  = v.addr;
    req_write_i = v.write;
    req_size_i  = v.size;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_i);
      accepted = req_ready_o;
      @(posedge clk_i);
      if (accepted) break;
    end
    if (accepted) sb_q.push_back(v);
    checkOutput("push_accept", accepted, 1);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic waitGrants(input string name, input int target, input int budget);
    for (int k = 0; k < budget && grant_count < target; k++) @(negedge clk_i);
    checkOutput(name, grant_count, target);
  endtask

  task automatic drainAll(input string name);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 80; k++) begin
      alignDrive();
      if (outstanding_o == '0 && sb_q.size() == 0 && idle_o) begin
        ok = 1'b1;
        break;
      end
      dp_done_i = (outstanding_o != '0);
    end
    dp_done_i = 1'b0;
    checkOutput(name, ok, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) vec_tbl[i] = '{32'h1000 + 32'(i) * 32'h10, 1'b0, 4'd4};
    for (int i = 0; i < 6; i++) vec_tbl[3 + i] = '{32'h2000 + 32'(i) * 32'h40, 1'b0, 4'(i + 1)};
    vec_tbl[9]  = '{32'h3000, 1'b0, 4'd2};
    vec_tbl[10] = '{32'h3100, 1'b1, 4'd8};
    for (int i = 0; i < 4; i++) vec_tbl[11 + i] = '{32'h4000 + 32'(i) * 32'h4, 1'b1, 4'd1};
    vec_tbl[15] = '{32'h6000, 1'b0, 4'd3};
    vec_tbl[16] = '{32'h6010, 1'b0, 4'd3};
    for (int i = 0; i < 5; i++) vec_tbl[17 + i] = '{32'h5000 + 32'(i) * 32'h100, 1'b0, 4'(9 + i)};
    vec_tbl[22] = '{32'h7000, 1'b0, 4'd5};
    vec_tbl[23] = '{32'h7020, 1'b0, 4'd6};

    reset_n_i = 1'b0; stop_i = 1'b0; req_valid_i = 1'b0; req_addr_i = '0;
    req_write_i = 1'b0; req_size_i = '0; bus_grant_i = 1'b0; bus_error_i = 1'b0; dp_done_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("rst_req_ready", req_ready_o, 1);
    checkOutput("rst_idle", idle_o, 1);
    checkOutput("rst_bus_req", bus_req_o, 0);
    checkOutput("rst_tk_push", tk_push_o, 0);
    checkOutput("rst_outstanding", outstanding_o, 0);
    checkOutput("rst_error", ap_state_error_o, 0);
    reset_n_i = 1'b1;
    alignDrive();

    $display("[TB] three reads, grant every cycle");
    bus_grant_i = 1'b1;
    grant_cyc_q.delete();
    base = grant_count;
    for (int i = 0; i < 3; i++) applyStimulus(vec_tbl[i]);
    waitGrants("t1_grants", base + 3, 10);
    checkOutput("t1_consecutive", (grant_cyc_q.size() >= 3) ? 64'(grant_cyc_q[2] - grant_cyc_q[0]) : 64'hFFFF, 2);
    @(negedge clk_i);
    checkOutput("t1_outstanding", outstanding_o, 3);
    checkOutput("t1_bus_req_empty", bus_req_o, 0);
    drainAll("t1_drain");

    $display("[TB] six reads against four outstanding");
    base = grant_count;
    for (int i = 3; i < 9; i++) applyStimulus(vec_tbl[i]);
    waitGrants("t2_grants4", base + 4, 20);
    repeat (3) @(negedge clk_i);
    checkOutput("t2_no_5th", grant_count, base + 4);
    checkOutput("t2_outstanding", outstanding_o, 4);
    checkOutput("t2_fence_req", bus_req_o, 0);
    checkOutput("t2_queued", sb_q.size(), 2);
    alignDrive(); dp_done_i = 1'b1;
    alignDrive(); dp_done_i = 1'b0;
    waitGrants("t2_grant5", base + 5, 10);
    @(negedge clk_i);
    checkOutput("t2_outstanding_after", outstanding_o, 4);
    drainAll("t2_drain");

    $display("[TB] read then write direction fence");
    alignDrive();
    base = grant_count;
    applyStimulus(vec_tbl[9]);
    waitGrants("t3_read_grant", base + 1, 10);
    @(negedge clk_i);
    checkOutput("t3_outstanding", outstanding_o, 1);
    alignDrive();
    applyStimulus(vec_tbl[10]);
    repeat (5) @(negedge clk_i);
    checkOutput("t3_fence_req", bus_req_o, 0);
    checkOutput("t3_write_held", grant_count, base + 1);
    alignDrive(); dp_done_i = 1'b1;
    alignDrive(); dp_done_i = 1'b0;
    waitGrants("t3_write_grant", base + 2, 10);
    checkOutput("t3_tk_write", last_tk_write, 1);
    drainAll("t3_drain");

    $display("[TB] stop with four ungranted requests");
    bus_grant_i = 1'b0;
    alignDrive();
    for (int i = 11; i < 15; i++) applyStimulus(vec_tbl[i]);
    @(negedge clk_i);
    checkOutput("t4_full_ready", req_ready_o, 0);
    checkOutput("t4_bus_req", bus_req_o, 1);
    checkOutput("t4_head_addr", bus_addr_o, 32'h4000);
    alignDrive(); stop_i = 1'b1; sb_q.delete();
    alignDrive(); stop_i = 1'b0;
    @(negedge clk_i);
    checkOutput("t4_req_dropped", bus_req_o, 0);
    checkOutput("t4_flush_ready", req_ready_o, 0);
    @(negedge clk_i);
    checkOutput("t4_idle", idle_o, 1);
    checkOutput("t4_ready_back", req_ready_o, 1);
    checkOutput("t4_no_error", ap_state_error_o, 0);

    $display("[TB] asynchronous reset with phases in flight");
    bus_grant_i = 1'b1;
    alignDrive();
    base = grant_count;
    applyStimulus(vec_tbl[15]);
    applyStimulus(vec_tbl[16]);
    waitGrants("rst_mid_grants", base + 2, 10);
    @(negedge clk_i);
    #2;
    bus_grant_i = 1'b0;
    reset_n_i   = 1'b0;
    #1;
    checkOutput("rst_mid_outstanding", outstanding_o, 0);
    checkOutput("rst_mid_idle", idle_o, 1);
    sb_q.delete();
    @(negedge clk_i);
    reset_n_i = 1'b1;

    $display("[TB] full FIFO push with grant, wrap and order");
    alignDrive();
    for (int i = 17; i < 21; i++) applyStimulus(vec_tbl[i]);
    @(negedge clk_i);
    checkOutput("t6_full_ready", req_ready_o, 0);
    alignDrive();
    bus_grant_i = 1'b1;
    applyStimulus(vec_tbl[21]);
    bus_grant_i = 1'b0;
    @(negedge clk_i);
    checkOutput("t6_still_full", req_ready_o, 0);
    checkOutput("t6_queued", sb_q.size(), 4);
    checkOutput("t6_next_head", bus_addr_o, 32'h5100);
    bus_grant_i = 1'b1;
    drainAll("t6_drain");
    checkOutput("t6_error_clear", ap_state_error_o, 0);
    alignDrive(); dp_done_i = 1'b1;
    alignDrive(); dp_done_i = 1'b0;
    @(negedge clk_i);
    checkOutput("t6_spurious_done_err", ap_state_error_o, 1);
    checkOutput("t6_outstanding_zero", outstanding_o, 0);

    $display("[TB] bus error with two outstanding");
    alignDrive();
    base = grant_count;
    applyStimulus(vec_tbl[22]);
    applyStimulus(vec_tbl[23]);
    waitGrants("t5_grants", base + 2, 10);
    @(negedge clk_i);
    checkOutput("t5_outstanding", outstanding_o, 2);
    alignDrive(); bus_error_i = 1'b1;
    alignDrive(); bus_error_i = 1'b0;
    @(negedge clk_i);
    checkOutput("t5_flush_ready", req_ready_o, 0);
    checkOutput("t5_flush_req", bus_req_o, 0);
    checkOutput("t5_error", ap_state_error_o, 1);
    repeat (3) @(negedge clk_i);
    checkOutput("t5_hold_outstanding", outstanding_o, 2);
    checkOutput("t5_hold_ready", req_ready_o, 0);
    alignDrive(); dp_done_i = 1'b1;
    alignDrive();
    alignDrive(); dp_done_i = 1'b0;
    @(negedge clk_i);
    checkOutput("t5_drained", outstanding_o, 0);
    checkOutput("t5_last_flush_ready", req_ready_o, 0);
    @(negedge clk_i);
    checkOutput("t5_idle", idle_o, 1);
    checkOutput("t5_ready_back", req_ready_o, 1);
    checkOutput("t5_error_sticky", ap_state_error_o, 1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
